// File: rtl/irq_ctrl_pkg.sv
// Shared constants and types for the two-line interrupt controller.
package irq_ctrl_pkg;

  localparam int unsigned BUS_W        = 8;
  localparam int unsigned IDX_W        = 3;
  localparam int unsigned ID_VALID_BIT = 7;

  localparam logic [2:0] OFS_PENDING = 3'd0;
  localparam logic [2:0] OFS_ENABLE  = 3'd1;
  localparam logic [2:0] OFS_ROUTE   = 3'd2;
  localparam logic [2:0] OFS_ID0     = 3'd3;
  localparam logic [2:0] OFS_ID1     = 3'd4;
  localparam logic [2:0] OFS_SWTRIG  = 3'd5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAISED = 2'd1,
    GAP    = 2'd2
  } line_state_e;

endpackage

// File: rtl/irq_line_fsm.sv
// One processor interrupt line: lowest-index arbitration, request hold until
// acknowledge, and a one-cycle low gap between back-to-back requests.
module irq_line_fsm
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] cand,
  input  logic               ack,
  output logic               raise,
  output logic [BUS_W-1:0]   id,
  output logic               clr_c,
  output logic [IDX_W-1:0]   clr_idx_c
);

  line_state_e      state_q, state_d;
  logic             raise_d;
  logic [BUS_W-1:0] id_d;
  logic [IDX_W-1:0] win_idx_c;

  // Lowest set index wins.
  always_comb begin
    win_idx_c = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (cand[i]) win_idx_c = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      raise   <= 1'b0;
      id      <= '0;
    end else begin
      state_q <= state_d;
      raise   <= raise_d;
      id      <= id_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    raise_d   = raise;
    id_d      = id;
    clr_c     = 1'b0;
    clr_idx_c = id[IDX_W-1:0];
    case (state_q)
      // The edge leaving GAP also arbitrates, so the low gap is exactly one cycle.
      IDLE, GAP: begin
        raise_d = 1'b0;
        state_d = IDLE;
        if (|cand) begin
          state_d          = RAISED;
          raise_d          = 1'b1;
          id_d             = BUS_W'(win_idx_c);
          id_d[ID_VALID_BIT] = 1'b1;
        end
      end
      RAISED: begin
        if (ack) begin
          state_d            = GAP;
          raise_d            = 1'b0;
          id_d[ID_VALID_BIT] = 1'b0;
          clr_c              = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        raise_d = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: edge capture, pending/enable/route
// registers and two independently arbitrated processor interrupt lines.
module irq_controller
  import irq_ctrl_pkg::*;
#(
  parameter logic [BUS_W-1:0] BASE_ADDR = 8'hE0,
  parameter int unsigned      NUM_SRC   = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  inout  wire  [BUS_W-1:0]   BUS_DATA,
  input  logic [BUS_W-1:0]   BUS_ADDR,
  input  logic               BUS_WE,
  input  logic [NUM_SRC-1:0] IRQ_IN,
  output logic [1:0]         BUS_INTERRUPTS_RAISE,
  input  logic [1:0]         BUS_INTERRUPTS_ACK
);

  logic [NUM_SRC-1:0] pending_q, enable_q, route_q, irq_prev_q;
  logic [NUM_SRC-1:0] pending_d, set_vec_c, clr_vec_c, wr_data_c;
  logic [BUS_W-1:0]   rd_data_q, rd_mux_c;
  logic               rd_oe_q;
  logic               in_win_c, wr_c, rd_c;
  logic [2:0]         ofs_c;
  logic [BUS_W-1:0]   unused_bus_data;

  logic [NUM_SRC-1:0] cand_c [2];
  logic [NUM_SRC-1:0] line_clr_vec_c [2];
  logic [BUS_W-1:0]   line_id [2];
  logic               line_clr_c [2];
  logic [IDX_W-1:0]   line_clr_idx_c [2];

  assign in_win_c        = (BUS_ADDR[BUS_W-1:3] == BASE_ADDR[BUS_W-1:3]);
  assign ofs_c           = BUS_ADDR[2:0];
  assign wr_c            = in_win_c & BUS_WE;
  assign rd_c            = in_win_c & ~BUS_WE;
  assign wr_data_c       = BUS_DATA[NUM_SRC-1:0];
  assign unused_bus_data = BUS_DATA;

  for (genvar l = 0; l < 2; l++) begin : g_line
    assign cand_c[l] = pending_q & enable_q & ((l == 1) ? route_q : ~route_q);
    assign line_clr_vec_c[l] = line_clr_c[l] ? (NUM_SRC'(1) << line_clr_idx_c[l]) : '0;

    irq_line_fsm #(.NUM_SRC(NUM_SRC)) u_fsm (
      .clk       (CLK),
      .rst_n     (RESET),
      .cand      (cand_c[l]),
      .ack       (BUS_INTERRUPTS_ACK[l]),
      .raise     (BUS_INTERRUPTS_RAISE[l]),
      .id        (line_id[l]),
      .clr_c     (line_clr_c[l]),
      .clr_idx_c (line_clr_idx_c[l])
    );
  end

  // Sets (edge or software trigger) win over clears of the same bit.
  always_comb begin
    set_vec_c = IRQ_IN & ~irq_prev_q;
    clr_vec_c = line_clr_vec_c[0] | line_clr_vec_c[1];
    if (wr_c && (ofs_c == OFS_SWTRIG))  set_vec_c = set_vec_c | wr_data_c;
    if (wr_c && (ofs_c == OFS_PENDING)) clr_vec_c = clr_vec_c | wr_data_c;
    pending_d = (pending_q & ~clr_vec_c) | set_vec_c;
  end

  always_comb begin
    rd_mux_c = '0;
    case (ofs_c)
      OFS_PENDING: rd_mux_c = BUS_W'(pending_q);
      OFS_ENABLE:  rd_mux_c = BUS_W'(enable_q);
      OFS_ROUTE:   rd_mux_c = BUS_W'(route_q);
      OFS_ID0:     rd_mux_c = line_id[0];
      OFS_ID1:     rd_mux_c = line_id[1];
      default:     rd_mux_c = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pending_q  <= '0;
      enable_q   <= '0;
      route_q    <= '0;
      irq_prev_q <= '0;
      rd_data_q  <= '0;
      rd_oe_q    <= 1'b0;
    end else begin
      irq_prev_q <= IRQ_IN;
      pending_q  <= pending_d;
      if (wr_c && (ofs_c == OFS_ENABLE)) enable_q <= wr_data_c;
      if (wr_c && (ofs_c == OFS_ROUTE))  route_q  <= wr_data_c;
      rd_oe_q <= rd_c;
      if (rd_c) rd_data_q <= rd_mux_c;
    end
  end

  assign BUS_DATA = rd_oe_q ? rd_data_q : {BUS_W{1'bz}};

endmodule

// File: tb/tb_irq_controller.sv
// Randomized and directed bench for irq_controller against a cycle-level
// behavioural model of the register map and the two interrupt lines.
module tb_irq_controller;

  localparam int unsigned NSRC = 4;
  localparam logic [7:0]  BASE = 8'hE0;
  localparam logic [7:0]  MASK = 8'h0F;

  logic       CLK;
  logic       RESET;
  wire  [7:0] bus_data;
  logic [7:0] bus_addr;
  logic       bus_we;
  logic [3:0] irq_in;
  logic [1:0] raise;
  logic [1:0] ack_in;
  logic [7:0] tb_wdata;
  logic       tb_drive;

  int n_cmp;
  int n_err;

  // Reference model state
  logic [7:0] m_pend, m_en, m_route;
  logic [3:0] m_prev;
  logic [1:0] m_raised;
  int         m_idx [2];
  logic [7:0] m_id [2];
  logic       m_rd_valid;
  logic [7:0] m_rd;
  logic [3:0] cur_irq;

  assign bus_data = tb_drive ? tb_wdata : 8'hzz;

  irq_controller #(.BASE_ADDR(BASE), .NUM_SRC(NSRC)) dut (
    .CLK                  (CLK),
    .RESET                (RESET),
    .BUS_DATA             (bus_data),
    .BUS_ADDR             (bus_addr),
    .BUS_WE               (bus_we),
    .IRQ_IN               (irq_in),
    .BUS_INTERRUPTS_RAISE (raise),
    .BUS_INTERRUPTS_ACK   (ack_in)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_en = '0; m_route = '0; m_prev = '0; m_raised = '0;
    m_idx[0] = 0; m_idx[1] = 0; m_id[0] = '0; m_id[1] = '0;
    m_rd_valid = 1'b0; m_rd = '0;
  endtask

  function automatic logic [7:0] m_reg(input logic [2:0] ofs);
    case (ofs)
      3'd0:    return m_pend;
      3'd1:    return m_en;
      3'd2:    return m_route;
      3'd3:    return m_id[0];
      3'd4:    return m_id[1];
      default: return 8'h00;
    endcase
  endfunction

  // One clock edge of the register map and both lines, from pre-edge values.
  task automatic model_step(input logic [3:0] irq, input logic [7:0] addr, input logic we,
                            input logic [7:0] wd, input logic [1:0] ack);
    logic       win;
    logic [2:0] ofs;
    logic [7:0] set, clr, rdv;
    bit         found;
    win = (addr[7:3] == BASE[7:3]);
    ofs = addr[2:0];
    rdv = m_reg(ofs);
    set = {4'b0, irq & ~m_prev};
    clr = '0;
    for (int l = 0; l < 2; l++) begin
      if (m_raised[l]) begin
        if (ack[l]) begin
          clr[m_idx[l]] = 1'b1;
          m_raised[l]   = 1'b0;
          m_id[l][7]    = 1'b0;
        end
      end else begin
        found = 1'b0;
        for (int j = 0; j < int'(NSRC); j++) begin
          if (!found && m_pend[j] && m_en[j] && (m_route[j] == (l == 1))) begin
            found       = 1'b1;
            m_raised[l] = 1'b1;
            m_idx[l]    = j;
            m_id[l]     = 8'h80 | 8'(j);
          end
        end
      end
    end
    if (win && we) begin
      case (ofs)
        3'd0:    clr = clr | wd;
        3'd1:    m_en = wd & MASK;
        3'd2:    m_route = wd & MASK;
        3'd5:    set = set | wd;
        default: ;
      endcase
    end
    m_pend     = ((m_pend & ~clr) | set) & MASK;
    m_prev     = irq;
    m_rd_valid = win && !we;
    m_rd       = rdv;
  endtask

  task automatic cycle(input logic [7:0] addr, input logic we, input logic [7:0] wd,
                       input logic [1:0] ack);
    @(negedge CLK);
    irq_in   = cur_irq;
    bus_addr = addr;
    bus_we   = we;
    tb_wdata = wd;
    tb_drive = we;
    ack_in   = ack;
    @(posedge CLK);
    model_step(cur_irq, addr, we, wd, ack);
    #1;
    check_eq("raise", 32'(raise), 32'({m_raised[1], m_raised[0]}));
    check_eq("bus_oe", 32'(dut.rd_oe_q), 32'(m_rd_valid));
    if (m_rd_valid) check_eq("rd_data", 32'(bus_data), 32'(m_rd));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(8'h00, 1'b0, 8'h00, 2'b00);
  endtask

  task automatic rd(input logic [2:0] ofs);
    cycle(BASE | 8'(ofs), 1'b0, 8'h00, 2'b00);
  endtask

  // A write right after a read would collide with the DUT's read drive.
  task automatic wr(input logic [2:0] ofs, input logic [7:0] d);
    if (m_rd_valid) idle(1);
    cycle(BASE | 8'(ofs), 1'b1, d, 2'b00);
  endtask

  task automatic ack(input logic [1:0] a);
    cycle(8'h00, 1'b0, 8'h00, a);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    cur_irq = '0; irq_in = '0; bus_addr = '0; bus_we = 1'b0;
    tb_wdata = '0; tb_drive = 1'b0; ack_in = '0;
    model_reset();
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    check_eq("reset_raise", 32'(raise), 32'h0);
    check_eq("reset_oe", 32'(dut.rd_oe_q), 32'h0);
    RESET = 1'b1;

    // Reset readback of the whole window
    for (int o = 0; o < 8; o++) rd(3'(o));
    idle(2);

    // Single source on line 0
    wr(3'd1, 8'h01); wr(3'd2, 8'h00);
    cur_irq = 4'b0001; idle(1);
    cur_irq = 4'b0000; idle(2);
    rd(3'd3); ack(2'b01); rd(3'd0); rd(3'd3); idle(1);

    // Two sources on two lines, simultaneous ack
    wr(3'd1, 8'h0F); wr(3'd2, 8'h0C);
    cur_irq = 4'b1010; idle(2);
    check_eq("two_line_raise", 32'(raise), 32'h3);
    cur_irq = 4'b0000;
    rd(3'd3); rd(3'd4); ack(2'b11); rd(3'd0); idle(2);

    // Back-to-back on line 0 with a one-cycle gap
    wr(3'd1, 8'h06); wr(3'd2, 8'h00);
    cur_irq = 4'b0110; idle(2);
    cur_irq = 4'b0000;
    rd(3'd3); ack(2'b01); idle(1); rd(3'd3); ack(2'b01); idle(2);

    // Re-edge beats W1C of the latched source
    wr(3'd1, 8'h04);
    cur_irq = 4'b0100; idle(2);
    cur_irq = 4'b0000; idle(1);
    cur_irq = 4'b0100; wr(3'd0, 8'h04);
    cur_irq = 4'b0000; rd(3'd0); idle(2);
    check_eq("hold_raise", 32'(raise), 32'h1);
    ack(2'b01); rd(3'd0); idle(2);

    // Software trigger while disabled, then enable
    wr(3'd1, 8'h00); wr(3'd5, 8'h08); idle(2); rd(3'd0);
    wr(3'd1, 8'h08); idle(2);
    check_eq("swtrig_raise", 32'(raise), 32'h1);

    // Asynchronous reset while raised
    @(negedge CLK);
    bus_we = 1'b0; tb_drive = 1'b0; bus_addr = 8'h00; ack_in = '0;
    #2 RESET = 1'b0;
    #1;
    check_eq("async_rst_raise", 32'(raise), 32'h0);
    check_eq("async_rst_oe", 32'(dut.rd_oe_q), 32'h0);
    model_reset();
    @(negedge CLK);
    RESET = 1'b1;
    idle(1);

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      int         op;
      logic [2:0] ofs;
      logic [7:0] addr;
      cur_irq = cur_irq ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
      op   = int'($urandom_range(0, 9));
      ofs  = 3'($urandom_range(0, 7));
      addr = ($urandom_range(0, 7) == 0) ? (8'hD8 | 8'(ofs)) : (BASE | 8'(ofs));
      if (op >= 7 && !m_rd_valid)
        cycle(addr, 1'b1, 8'($urandom_range(0, 255)),
              2'($urandom_range(0, 3) & $urandom_range(0, 3)));
      else if (op >= 4)
        cycle(addr, 1'b0, 8'h00, 2'($urandom_range(0, 3) & $urandom_range(0, 3)));
      else
        cycle(8'h00, 1'b0, 8'h00, 2'($urandom_range(0, 3) & $urandom_range(0, 3)));
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
Memory-mapped interrupt controller on the shared 8-bit bus, between up to 8 peripheral interrupt sources and the processor's two interrupt lines.
- Latches source rising edges into a pending register, applies enable and line routing, and raises the processor line.
- Presents the winning source ID for readback, and clears that source when the processor acknowledges.
- Lets the timer, VGA and future peripherals share two processor vectors.

Parameters:
BASE_ADDR, 8'hE0, first bus address of the 8-byte register window (BASE_ADDR[2:0] must be 0)
NUM_SRC, 4, number of interrupt sources (1..8); unused register bits read 0

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-low reset
BUS_DATA  inout  8  shared data bus; driven only during own read, else high-Z
BUS_ADDR  in  8  shared address bus
BUS_WE  in  1  bus write strobe (1 = write, 0 = read)
IRQ_IN  in  NUM_SRC  peripheral requests, same clock domain, rising edge = request
BUS_INTERRUPTS_RAISE  out  2  interrupt request to processor, one per line
BUS_INTERRUPTS_ACK  in  2  processor acknowledge, one-cycle pulse per line

Behaviour:
- Register map (offset from BASE_ADDR):
  - 0 PENDING: read; write-1-to-clear.
  - 1 ENABLE: read/write.
  - 2 ROUTE: read/write; bit=1 routes the source to line 1, bit=0 to line 0.
  - 3 ID0: read-only; bit7 = valid, bits2:0 = source index.
  - 4 ID1: read-only, same format as ID0.
  - 5 SWTRIG: write-only; write-1 sets PENDING; reads 0.
  - 6..7: reserved; read 0, writes ignored.
- Reset (RESET=0, async): PENDING/ENABLE/ROUTE = 0, ID0/ID1 = 0, RAISE = 2'b00, BUS_DATA high-Z, edge-detect history = 0, both line FSMs in IDLE.
- Write: at the clock edge where BUS_WE=1 and the address is in the window, the register updates; the new value is visible from the next cycle.
- Read: at edge N with BUS_WE=0 and the address in the window, read data and output-enable are registered. BUS_DATA is driven during cycle N+1 only, then high-Z.
- Edge detect: a source is pending when IRQ_IN[i]=1 and its previous sample is 0. PENDING[i] is set after that edge.
- Set/clear priority within one cycle:
  - An edge or SWTRIG set beats a W1C clear or ACK clear of the same bit.
  - A W1C or ACK clear on other bits is applied normally.
- Candidate for line L = PENDING & ENABLE & (ROUTE==L). Priority: lowest index wins.
- Line FSM (one per line):
  - IDLE: if the candidate is non-zero, go to RAISED next edge; latch ID with bit7=1 and assert RAISE[L].
    - Latency: IRQ_IN edge at k -> PENDING after k -> RAISE after k+1.
  - RAISED: hold RAISE[L]=1 and the latched ID. Disabling the source, rerouting it or W1C does not retract the request.
    - On ACK[L]=1: clear PENDING[latched index] (unless re-set in the same cycle), clear ID bit7, RAISE[L]=0, go to GAP.
  - GAP: RAISE[L]=0 for exactly one cycle, then IDLE. Back-to-back interrupts therefore show a 1-cycle low gap.
  - ACK[L] in IDLE or GAP is ignored.
- Both lines operate independently. Simultaneous ACK on both lines clears both latched bits in the same cycle.
- A source pending with ENABLE=0 stays pending; it raises the line once enabled.
- Reset mid-operation: immediate return to reset state, including dropping RAISE and releasing BUS_DATA.

Decomposition:
- Package irq_ctrl_pkg holds:
  - register offset constants (OFS_PENDING..OFS_SWTRIG)
  - the line state enum (IDLE, RAISED, GAP)
  - the ID valid bit position
- Sub-module irq_line_fsm, instantiated twice. It contains:
  - inputs: candidate vector and ack
  - outputs: raise, latched ID, clear strobe with index
  - the lowest-index priority encoder and the FSM
- The top level holds the bus decode, the registers and edge detection.

Test Plan:
- Reset then read all offsets 0..7 -> every read returns 8'h00; RAISE=00; BUS_DATA high-Z outside read cycles.
- ENABLE=8'h01, ROUTE=0, pulse IRQ_IN[0] at edge k -> PENDING=01 after k, RAISE[0]=1 after k+1, ID0=8'h80; ACK[0] -> RAISE[0]=0, PENDING=00, ID0=00.
- ENABLE=8'h0F, ROUTE=8'h0C, rising edges on sources 1 and 3 in the same cycle -> RAISE=2'b11, ID0=8'h81, ID1=8'h83; simultaneous ACK=11 -> PENDING=00.
- ENABLE=8'h06, edges on sources 1 and 2 together, line 0 -> ID0=8'h81; ACK -> exactly 1 cycle RAISE[0]=0, then ID0=8'h82.
- In RAISED with source 2, W1C PENDING=8'h04 and a new source-2 edge in the same cycle -> PENDING[2] stays 1; RAISE stays 1 until ACK.
- SWTRIG write 8'h08 with ENABLE=0 -> PENDING=08, no RAISE; then ENABLE=08 -> RAISE[0] after 1 cycle; assert RESET=0 while raised -> RAISE=00 immediately.
